// File: rtl/mem_stage_unit.sv
// Memory-stage engine: drives the 16-bit data memory from EX/MEM outputs and
// splits 32-bit stack transfers into two beats, stalling upstream on beat 0.
module mem_stage_unit #(
  parameter int NUMBER_CONTROL_SIGNALS = 16,
  parameter int ADDR_WIDTH             = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUMBER_CONTROL_SIGNALS-1:0] ctrl_in,
  input  logic                              mem_read_in,
  input  logic                              mem_write_in,
  input  logic                              wide_in,
  input  logic                              use_sp_in,
  input  logic [15:0]                       result_in,
  input  logic [15:0]                       address_in,
  input  logic [15:0]                       store_data_in,
  input  logic [31:0]                       wide_data_in,
  input  logic [ADDR_WIDTH-1:0]             sp_in,
  input  logic [3:0]                        reg_dst_num_in,
  input  logic                              reg_wb_en_in,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [15:0]                       mem_wdata,
  output logic                              mem_we,
  output logic                              mem_re,
  input  logic [15:0]                       mem_rdata,
  output logic                              stall_out,
  output logic [NUMBER_CONTROL_SIGNALS-1:0] ctrl_out,
  output logic [15:0]                       wb_data,
  output logic [3:0]                        wb_reg_num,
  output logic                              wb_en,
  output logic [31:0]                       wide_out,
  output logic                              wide_valid
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BEAT1 = 1'b1
  } state_t;

  state_t                            state_q, state_d;
  logic [ADDR_WIDTH-1:0]             next_addr_q, next_addr_d;
  logic [15:0]                       lo_data_q, lo_data_d;
  logic [15:0]                       hi_data_q, hi_data_d;
  logic                              wide_wr_q, wide_wr_d;
  logic [NUMBER_CONTROL_SIGNALS-1:0] ctrl_q, ctrl_d;
  logic [3:0]                        wb_reg_num_q, wb_reg_num_d;
  logic                              wb_en_q, wb_en_d;
  logic [15:0]                       result_q, result_d;
  logic                              is_load_q, is_load_d;
  logic                              wide_valid_q, wide_valid_d;
  logic [31:0]                       wide_hold_q, wide_hold_d;

  logic [ADDR_WIDTH-1:0] eff_addr;
  logic                  rd_only;
  logic                  wide_start;

  // Effective address and request decode; a read+write conflict counts as a write.
  always_comb begin
    eff_addr   = use_sp_in ? sp_in : {{(ADDR_WIDTH-16){1'b0}}, address_in};
    rd_only    = mem_read_in & ~mem_write_in;
    wide_start = (state_q == S_IDLE) & wide_in & (mem_read_in | mem_write_in);
  end

  // Next-state, memory strobes and writeback register inputs.
  always_comb begin
    state_d      = state_q;
    next_addr_d  = next_addr_q;
    lo_data_d    = lo_data_q;
    hi_data_d    = hi_data_q;
    wide_wr_d    = wide_wr_q;
    ctrl_d       = ctrl_in;
    wb_reg_num_d = reg_dst_num_in;
    wb_en_d      = reg_wb_en_in;
    result_d     = result_in;
    is_load_d    = 1'b0;
    wide_valid_d = 1'b0;
    wide_hold_d  = wide_valid_q ? {hi_data_q, mem_rdata} : wide_hold_q;
    mem_addr     = eff_addr;
    mem_wdata    = store_data_in;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    stall_out    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wide_start) begin
          mem_wdata    = wide_data_in[31:16];
          mem_we       = mem_write_in;
          mem_re       = rd_only;
          stall_out    = 1'b1;
          next_addr_d  = eff_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          lo_data_d    = wide_data_in[15:0];
          wide_wr_d    = mem_write_in;
          state_d      = S_BEAT1;
          // Bubble into writeback while the second beat completes.
          ctrl_d       = {NUMBER_CONTROL_SIGNALS{1'b0}};
          wb_reg_num_d = 4'd0;
          wb_en_d      = 1'b0;
          result_d     = 16'h0000;
        end else begin
          mem_we    = mem_write_in;
          mem_re    = rd_only;
          is_load_d = rd_only;
        end
      end
      S_BEAT1: begin
        mem_addr     = next_addr_q;
        mem_wdata    = lo_data_q;
        mem_we       = wide_wr_q;
        mem_re       = ~wide_wr_q;
        // Beat-0 read data arrives now; the low half arrives next cycle.
        hi_data_d    = wide_wr_q ? hi_data_q : mem_rdata;
        wide_valid_d = ~wide_wr_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!reset) begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      stall_out = 1'b0;
    end else begin
      stall_out = stall_out;
    end
  end

  // State and writeback registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      next_addr_q  <= {ADDR_WIDTH{1'b0}};
      lo_data_q    <= 16'h0000;
      hi_data_q    <= 16'h0000;
      wide_wr_q    <= 1'b0;
      ctrl_q       <= {NUMBER_CONTROL_SIGNALS{1'b0}};
      wb_reg_num_q <= 4'd0;
      wb_en_q      <= 1'b0;
      result_q     <= 16'h0000;
      is_load_q    <= 1'b0;
      wide_valid_q <= 1'b0;
      wide_hold_q  <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      next_addr_q  <= next_addr_d;
      lo_data_q    <= lo_data_d;
      hi_data_q    <= hi_data_d;
      wide_wr_q    <= wide_wr_d;
      ctrl_q       <= ctrl_d;
      wb_reg_num_q <= wb_reg_num_d;
      wb_en_q      <= wb_en_d;
      result_q     <= result_d;
      is_load_q    <= is_load_d;
      wide_valid_q <= wide_valid_d;
      wide_hold_q  <= wide_hold_d;
    end
  end

  // Load data and the low half of a wide read pass straight through from memory.
  always_comb begin
    ctrl_out   = ctrl_q;
    wb_reg_num = wb_reg_num_q;
    wb_en      = wb_en_q;
    wb_data    = is_load_q ? mem_rdata : result_q;
    wide_valid = wide_valid_q;
    wide_out   = wide_valid_q ? {hi_data_q, mem_rdata} : wide_hold_q;
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: directed scenarios plus randomized
// back-to-back traffic checked against an operation-level reference model.
module tb_mem_stage_unit;
  logic        clk, reset;
  logic [15:0] ctrl_in;
  logic        mem_read_in, mem_write_in, wide_in, use_sp_in;
  logic [15:0] result_in, address_in, store_data_in;
  logic [31:0] wide_data_in, sp_in;
  logic [3:0]  reg_dst_num_in;
  logic        reg_wb_en_in;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_re, stall_out;
  logic [15:0] ctrl_out, wb_data;
  logic [3:0]  wb_reg_num;
  logic        wb_en, wide_valid;
  logic [31:0] wide_out;

  int checks = 0;
  int passes = 0;

  // Environment memory, with a bench-side preload port.
  logic [15:0] env_mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;

  // Reference memory, keyed by full address.
  logic [15:0] ref_mem [bit [31:0]];

  mem_stage_unit #(.NUMBER_CONTROL_SIGNALS(16), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .wide_in(wide_in), .use_sp_in(use_sp_in),
    .result_in(result_in), .address_in(address_in), .store_data_in(store_data_in),
    .wide_data_in(wide_data_in), .sp_in(sp_in), .reg_dst_num_in(reg_dst_num_in),
    .reg_wb_en_in(reg_wb_en_in), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .stall_out(stall_out),
    .ctrl_out(ctrl_out), .wb_data(wb_data), .wb_reg_num(wb_reg_num), .wb_en(wb_en),
    .wide_out(wide_out), .wide_valid(wide_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) env_mem[pl_addr] <= pl_data;
    else if (mem_we) env_mem[mem_addr[9:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= env_mem[mem_addr[9:0]];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [15:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ctrl_in = 16'h0; mem_read_in = 1'b0; mem_write_in = 1'b0; wide_in = 1'b0;
    use_sp_in = 1'b0; result_in = 16'h0; address_in = 16'h0; store_data_in = 16'h0;
    wide_data_in = 32'h0; sp_in = 32'h0; reg_dst_num_in = 4'h0; reg_wb_en_in = 1'b0;
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs;
    mem_read_in = 1'b1; mem_write_in = 1'b1; wide_in = 1'b1; result_in = 16'hFFFF;
    reset = 1'b0;
    tick; tick;
    checks++;
    if ({ctrl_out, wb_data, wb_reg_num, wb_en, wide_out, wide_valid} !== 69'd0)
      $display("FAIL reset_regs: got ctrl=%h wb=%h reg=%h en=%b wide=%h v=%b, want all 0",
               ctrl_out, wb_data, wb_reg_num, wb_en, wide_out, wide_valid);
    else passes++;
    checks++;
    if ({mem_we, mem_re, stall_out} !== 3'b000)
      $display("FAIL reset_strobes: got we/re/stall=%b, want 000", {mem_we, mem_re, stall_out});
    else passes++;
    idle_inputs;
    reset = 1'b1;
    tick;
  endtask

  task automatic init_mem;
    for (int i = 0; i < 1024; i++) preload(i[9:0], 16'h0000);
  endtask

  task automatic test_narrow_store;
    idle_inputs;
    address_in = 16'h0010; store_data_in = 16'hBEEF; mem_write_in = 1'b1; result_in = 16'h5A5A;
    #1;
    checks++;
    if ({mem_addr, mem_wdata, mem_we, mem_re, stall_out} !== {32'h10, 16'hBEEF, 3'b100})
      $display("FAIL narrow_store_bus: got addr=%h wd=%h we/re/st=%b, want 10 BEEF 100",
               mem_addr, mem_wdata, {mem_we, mem_re, stall_out});
    else passes++;
    tick;
    checks++;
    if ({wb_data, stall_out} !== {16'h5A5A, 1'b0})
      $display("FAIL narrow_store_wb: got wb=%h stall=%b, want 5A5A 0", wb_data, stall_out);
    else passes++;
    idle_inputs;
  endtask

  task automatic test_narrow_load;
    preload(10'h020, 16'h1234);
    idle_inputs;
    address_in = 16'h0020; mem_read_in = 1'b1; reg_dst_num_in = 4'd3; reg_wb_en_in = 1'b1;
    ctrl_in = 16'hC0DE; result_in = 16'h9999;
    #1;
    checks++;
    if ({mem_addr, mem_we, mem_re, stall_out} !== {32'h20, 3'b010})
      $display("FAIL narrow_load_bus: got addr=%h we/re/st=%b, want 20 010",
               mem_addr, {mem_we, mem_re, stall_out});
    else passes++;
    tick;
    checks++;
    if ({wb_data, wb_reg_num, wb_en, ctrl_out} !== {16'h1234, 4'd3, 1'b1, 16'hC0DE})
      $display("FAIL narrow_load_wb: got wb=%h reg=%0d en=%b ctrl=%h, want 1234 3 1 C0DE",
               wb_data, wb_reg_num, wb_en, ctrl_out);
    else passes++;
    idle_inputs;
  endtask

  task automatic test_wide_push;
    idle_inputs;
    use_sp_in = 1'b1; sp_in = 32'h3FE; wide_in = 1'b1; mem_write_in = 1'b1;
    wide_data_in = 32'hAABBCCDD; ctrl_in = 16'h00F1; reg_wb_en_in = 1'b1;
    reg_dst_num_in = 4'd5; result_in = 16'h0777;
    #1;
    checks++;
    if ({mem_addr, mem_wdata, mem_we, mem_re, stall_out} !== {32'h3FE, 16'hAABB, 3'b101})
      $display("FAIL push_beat0: got addr=%h wd=%h we/re/st=%b, want 3FE AABB 101",
               mem_addr, mem_wdata, {mem_we, mem_re, stall_out});
    else passes++;
    tick;
    checks++;
    if ({wb_en, ctrl_out} !== 17'd0)
      $display("FAIL push_bubble: got en=%b ctrl=%h, want 0 0", wb_en, ctrl_out);
    else passes++;
    checks++;
    if ({mem_addr, mem_wdata, mem_we, mem_re, stall_out} !== {32'h3FF, 16'hCCDD, 3'b100})
      $display("FAIL push_beat1: got addr=%h wd=%h we/re/st=%b, want 3FF CCDD 100",
               mem_addr, mem_wdata, {mem_we, mem_re, stall_out});
    else passes++;
    tick;
    checks++;
    if ({ctrl_out, wb_reg_num, wb_en, wb_data, wide_valid} !== {16'h00F1, 4'd5, 1'b1, 16'h0777, 1'b0})
      $display("FAIL push_wb: got ctrl=%h reg=%0d en=%b wb=%h v=%b, want 00F1 5 1 0777 0",
               ctrl_out, wb_reg_num, wb_en, wb_data, wide_valid);
    else passes++;
    checks++;
    if ({env_mem[10'h3FE], env_mem[10'h3FF]} !== 32'hAABBCCDD)
      $display("FAIL push_memory: got %h%h, want AABBCCDD", env_mem[10'h3FE], env_mem[10'h3FF]);
    else passes++;
    idle_inputs;
    #1;
    checks++;
    if ({mem_we, stall_out} !== 2'b00)
      $display("FAIL push_idle: got we/stall=%b, want 00", {mem_we, stall_out});
    else passes++;
  endtask

  task automatic test_wide_pop;
    preload(10'h3FE, 16'h1111);
    preload(10'h3FF, 16'h2222);
    idle_inputs;
    use_sp_in = 1'b1; sp_in = 32'h3FE; wide_in = 1'b1; mem_read_in = 1'b1;
    #1;
    checks++;
    if ({mem_addr, mem_we, mem_re, stall_out} !== {32'h3FE, 3'b011})
      $display("FAIL pop_beat0: got addr=%h we/re/st=%b, want 3FE 011", mem_addr, {mem_we, mem_re, stall_out});
    else passes++;
    tick;
    checks++;
    if ({mem_addr, mem_we, mem_re, stall_out, wide_valid} !== {32'h3FF, 4'b0100})
      $display("FAIL pop_beat1: got addr=%h we/re/st/v=%b, want 3FF 0100",
               mem_addr, {mem_we, mem_re, stall_out, wide_valid});
    else passes++;
    tick;
    idle_inputs;
    #1;
    checks++;
    if ({wide_out, wide_valid} !== {32'h11112222, 1'b1})
      $display("FAIL pop_result: got wide=%h v=%b, want 11112222 1", wide_out, wide_valid);
    else passes++;
    tick;
    checks++;
    if ({wide_out, wide_valid} !== {32'h11112222, 1'b0})
      $display("FAIL pop_hold: got wide=%h v=%b, want 11112222 0", wide_out, wide_valid);
    else passes++;
  endtask

  task automatic test_wrap;
    idle_inputs;
    use_sp_in = 1'b1; sp_in = 32'hFFFF_FFFF; wide_in = 1'b1; mem_write_in = 1'b1;
    wide_data_in = 32'h1234_5678;
    #1;
    checks++;
    if ({mem_addr, mem_wdata, stall_out} !== {32'hFFFF_FFFF, 16'h1234, 1'b1})
      $display("FAIL wrap_beat0: got addr=%h wd=%h st=%b, want FFFFFFFF 1234 1", mem_addr, mem_wdata, stall_out);
    else passes++;
    tick;
    checks++;
    if ({mem_addr, mem_wdata, mem_we, stall_out} !== {32'h0, 16'h5678, 2'b10})
      $display("FAIL wrap_beat1: got addr=%h wd=%h we/st=%b, want 0 5678 10",
               mem_addr, mem_wdata, {mem_we, stall_out});
    else passes++;
    tick;
    idle_inputs;
  endtask

  task automatic test_reset_beat1;
    preload(10'h3FE, 16'h1111);
    preload(10'h3FF, 16'h2222);
    idle_inputs;
    use_sp_in = 1'b1; sp_in = 32'h3FE; wide_in = 1'b1; mem_read_in = 1'b1;
    ctrl_in = 16'h5555; reg_wb_en_in = 1'b1; reg_dst_num_in = 4'd7; result_in = 16'h7777;
    tick;
    checks++;
    if ({mem_addr, stall_out} !== {32'h3FF, 1'b0})
      $display("FAIL rst_b1_entry: got addr=%h st=%b, want 3FF 0", mem_addr, stall_out);
    else passes++;
    reset = 1'b0;
    tick;
    checks++;
    if ({ctrl_out, wb_data, wb_reg_num, wb_en, wide_out, wide_valid} !== 69'd0)
      $display("FAIL rst_b1_regs: got ctrl=%h wb=%h reg=%h en=%b wide=%h v=%b, want all 0",
               ctrl_out, wb_data, wb_reg_num, wb_en, wide_out, wide_valid);
    else passes++;
    reset = 1'b1;
    idle_inputs;
    address_in = 16'h0010; mem_read_in = 1'b1;
    #1;
    checks++;
    if ({mem_addr, mem_re, stall_out} !== {32'h10, 2'b10})
      $display("FAIL rst_b1_idle: got addr=%h re/st=%b, want 10 10", mem_addr, {mem_re, stall_out});
    else passes++;
    tick;
    checks++;
    if (wide_valid !== 1'b0)
      $display("FAIL rst_b1_novalid: got v=%b, want 0", wide_valid);
    else passes++;
    idle_inputs;
  endtask

  task automatic test_conflict;
    idle_inputs;
    address_in = 16'h0030; store_data_in = 16'h4321; mem_read_in = 1'b1; mem_write_in = 1'b1;
    reg_wb_en_in = 1'b1; result_in = 16'h0042;
    #1;
    checks++;
    if ({mem_we, mem_re, mem_wdata} !== {2'b10, 16'h4321})
      $display("FAIL conflict_bus: got we/re=%b wd=%h, want 10 4321", {mem_we, mem_re}, mem_wdata);
    else passes++;
    tick;
    checks++;
    if (wb_data !== 16'h0042)
      $display("FAIL conflict_wb: got wb=%h, want 0042", wb_data);
    else passes++;
    idle_inputs;
  endtask

  task automatic test_random_back_to_back;
    logic [31:0] r, a, wd;
    logic        rd, wr, wide, usp, wben, ld;
    logic [15:0] ctrl, res, sd, exp_wb;
    logic [3:0]  dst;
    for (int n = 0; n < 250; n++) begin
      r = $urandom; rd = r[0]; wr = r[1]; wide = (r[3:2] == 2'b00); usp = r[4]; wben = r[5]; dst = r[9:6];
      r = $urandom; ctrl = r[15:0]; res = r[31:16];
      r = $urandom; sd = r[15:0];
      wd = $urandom;
      r = $urandom; a = usp ? (32'h100 + {24'h0, r[7:0]}) : {16'h0, 8'h01, r[15:8]};
      ctrl_in = ctrl; mem_read_in = rd; mem_write_in = wr; wide_in = wide; use_sp_in = usp;
      result_in = res; address_in = a[15:0]; store_data_in = sd; wide_data_in = wd;
      sp_in = a; reg_dst_num_in = dst; reg_wb_en_in = wben;
      #1;
      if (wide && (rd || wr)) begin
        checks++;
        if ({mem_addr, mem_we, mem_re, stall_out} !== {a, wr, !wr, 1'b1} || (wr && mem_wdata !== wd[31:16]))
          $display("FAIL rnd_wide_b0 #%0d: got addr=%h wd=%h we/re/st=%b, want %h %h %b",
                   n, mem_addr, mem_wdata, {mem_we, mem_re, stall_out}, a, wd[31:16], {wr, !wr, 1'b1});
        else passes++;
        tick;
        checks++;
        if ({mem_addr, mem_we, mem_re, stall_out, wb_en, ctrl_out} !== {a + 32'd1, wr, !wr, 1'b0, 17'd0} ||
            (wr && mem_wdata !== wd[15:0]))
          $display("FAIL rnd_wide_b1 #%0d: got addr=%h wd=%h we/re/st=%b en=%b ctrl=%h, want %h %h %b 0 0",
                   n, mem_addr, mem_wdata, {mem_we, mem_re, stall_out}, wb_en, ctrl_out,
                   a + 32'd1, wd[15:0], {wr, !wr, 1'b0});
        else passes++;
        tick;
        checks++;
        if ({ctrl_out, wb_reg_num, wb_en, wb_data, wide_valid} !== {ctrl, dst, wben, res, !wr} ||
            (!wr && wide_out !== {ref_rd(a), ref_rd(a + 32'd1)}))
          $display("FAIL rnd_wide_done #%0d: got ctrl=%h reg=%h en=%b wb=%h v=%b wide=%h, want %h %h %b %h %b %h",
                   n, ctrl_out, wb_reg_num, wb_en, wb_data, wide_valid, wide_out,
                   ctrl, dst, wben, res, !wr, {ref_rd(a), ref_rd(a + 32'd1)});
        else passes++;
        if (wr) begin
          ref_mem[a] = wd[31:16];
          ref_mem[a + 32'd1] = wd[15:0];
        end
      end else begin
        ld = rd && !wr;
        checks++;
        if ({mem_addr, mem_we, mem_re, stall_out} !== {a, wr, ld, 1'b0} || (wr && mem_wdata !== sd))
          $display("FAIL rnd_narrow_bus #%0d: got addr=%h wd=%h we/re/st=%b, want %h %h %b",
                   n, mem_addr, mem_wdata, {mem_we, mem_re, stall_out}, a, sd, {wr, ld, 1'b0});
        else passes++;
        exp_wb = ld ? ref_rd(a) : res;
        tick;
        checks++;
        if ({ctrl_out, wb_reg_num, wb_en, wb_data, wide_valid} !== {ctrl, dst, wben, exp_wb, 1'b0})
          $display("FAIL rnd_narrow_wb #%0d: got ctrl=%h reg=%h en=%b wb=%h v=%b, want %h %h %b %h 0",
                   n, ctrl_out, wb_reg_num, wb_en, wb_data, wide_valid, ctrl, dst, wben, exp_wb);
        else passes++;
        if (wr) ref_mem[a] = sd;
      end
    end
    idle_inputs;
  endtask

  initial begin
    pl_en = 1'b0; pl_addr = 10'h0; pl_data = 16'h0;
    reset = 1'b0;
    idle_inputs;
    test_reset;
    init_mem;
    test_narrow_store;
    test_narrow_load;
    test_wide_push;
    test_wide_pop;
    test_wrap;
    test_reset_beat1;
    test_conflict;
    test_random_back_to_back;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
